decompress_unpack: RTL and testbench

Streaming decoder for Kyber ciphertext and message fields. It consumes a packed byte stream, unpacks consecutive d-bit fields LSB-first, and decompresses each field y to a 12-bit coefficient round(q/2^d * y) with q = 3329. It processes one polynomial of 256 coefficients per start and performs the inverse of the compression step. It sits between the ciphertext byte interface and the NTT/polynomial RAM write port in decapsulation.

---
 rtl/kyber_pkg.sv | 25 ++
 rtl/decompress_unpack_decompress.sv | 23 ++
 rtl/decompress_unpack.sv | 133 +++++++++++++
 tb/tb_decompress_unpack.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the FSM state type for the ciphertext decode path.
// The legal compression widths are the only ones allowed into the datapath.
package kyber_pkg;

   localparam int KYBER_Q = 3329;
   localparam int KYBER_N = 256;
   localparam int BUF_W   = 24;

   localparam logic [3:0] D_MSG = 4'd1;
   localparam logic [3:0] D_V4  = 4'd4;
   localparam logic [3:0] D_V5  = 4'd5;
   localparam logic [3:0] D_U10 = 4'd10;
   localparam logic [3:0] D_U11 = 4'd11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic is_legal_d(input logic [3:0] d);
      return (d == D_MSG) || (d == D_V4) || (d == D_V5) ||
             (d == D_U10) || (d == D_U11);
   endfunction

endpackage

// File: rtl/decompress_unpack_decompress.sv
// Combinational Kyber decompression: coeff = round(Q * y / 2^d).
// Q is expanded into shifts so the multiply becomes a four-term adder tree.
module decompress
   import kyber_pkg::*;
(
   input  logic [10:0] y,
   input  logic [3:0]  d,
   output logic [11:0] coeff
);

   logic [23:0] y_w;
   logic [23:0] prod;
   logic [23:0] rnd;
   logic [23:0] sum;

   // 3329 = 2^11 + 2^10 + 2^8 + 1; the sum stays below 2^23 for y < 2^11.
   assign y_w   = 24'(y);
   assign prod  = (y_w << 11) + (y_w << 10) + (y_w << 8) + y_w;
   assign rnd   = 24'd1 << (d - 4'd1);
   assign sum   = prod + rnd;
   assign coeff = 12'(sum >> d);

endmodule

// File: rtl/decompress_unpack.sv
// Streaming unpacker: packed LSB-first bytes in, d-bit fields out, each
// decompressed to a 12-bit coefficient, one polynomial per start.
module decompress_unpack
   import kyber_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_start,
   input  logic [3:0]  i_d,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_valid,
   output logic        o_byte_ready,
   output logic [11:0] o_coeff,
   output logic        o_coeff_valid,
   input  logic        i_coeff_ready,
   output logic        o_busy,
   output logic        o_done
);

   state_t state;
   state_t state_next;

   logic [3:0]       d_r;
   logic [BUF_W-1:0] bit_buf;
   logic [4:0]       buf_cnt;
   logic [8:0]       bytes_in;
   logic [8:0]       coeffs_out;

   logic             run;
   logic             start_ok;
   logic [8:0]       byte_limit;
   logic             accept;
   logic             extract;
   logic             handshake;
   logic             last;
   logic [10:0]      y;
   logic [11:0]      coeff_next;

   logic [BUF_W-1:0] buf_shift;
   logic [BUF_W-1:0] buf_next;
   logic [4:0]       cnt_shift;
   logic [4:0]       cnt_next;

   assign start_ok   = i_start && is_legal_d(i_d);
   assign byte_limit = {d_r, 5'b0};
   assign accept     = o_byte_ready && i_byte_valid;
   assign extract    = run && (buf_cnt >= {1'b0, d_r}) &&
                       (!o_coeff_valid || i_coeff_ready);
   assign handshake  = o_coeff_valid && i_coeff_ready;
   assign last       = handshake && (coeffs_out == 9'(KYBER_N - 1));
   assign y          = bit_buf[10:0] & ((11'd1 << d_r) - 11'd1);

   decompress u_decompress (
      .y     (y),
      .d     (d_r),
      .coeff (coeff_next)
   );

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_next;
   end

   // NOTE: default assignment first so no path leaves state_next unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start_ok) state_next = RUN;
         RUN:  if (last)     state_next = IDLE;
         default:            state_next = IDLE;
      endcase
   end

   always_comb begin
      run          = (state == RUN);
      o_busy       = run;
      o_byte_ready = run && (bytes_in < byte_limit) &&
                     (buf_cnt <= 5'(BUF_W - 8));
   end

   // A byte accepted in the same cycle as an extraction lands just above
   // the bits that survive the shift.
   always_comb begin
      buf_shift = extract ? (bit_buf >> d_r) : bit_buf;
      cnt_shift = extract ? (buf_cnt - {1'b0, d_r}) : buf_cnt;
      buf_next  = buf_shift;
      cnt_next  = cnt_shift;
      if (accept) begin
         buf_next = buf_shift | (BUF_W'(i_byte) << cnt_shift);
         cnt_next = cnt_shift + 5'd8;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         d_r           <= '0;
         bit_buf       <= '0;
         buf_cnt       <= '0;
         bytes_in      <= '0;
         coeffs_out    <= '0;
         o_coeff       <= '0;
         o_coeff_valid <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         o_done <= last;
         if (!run) begin
            if (start_ok) begin
               d_r           <= i_d;
               bit_buf       <= '0;
               buf_cnt       <= '0;
               bytes_in      <= '0;
               coeffs_out    <= '0;
               o_coeff_valid <= 1'b0;
            end
         end else begin
            bit_buf <= buf_next;
            buf_cnt <= cnt_next;
            if (accept)    bytes_in   <= bytes_in + 9'd1;
            if (handshake) coeffs_out <= coeffs_out + 9'd1;
            if (extract) begin
               o_coeff       <= coeff_next;
               o_coeff_valid <= 1'b1;
            end else if (handshake) begin
               o_coeff_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_decompress_unpack.sv
// Directed bench for decompress_unpack: fixed and random byte streams,
// backpressure, illegal/overlapping starts and mid-polynomial reset.
module tb_decompress_unpack;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_start;
   logic [3:0]  i_d;
   logic [7:0]  i_byte;
   logic        i_byte_valid;
   logic        o_byte_ready;
   logic [11:0] o_coeff;
   logic        o_coeff_valid;
   logic        i_coeff_ready;
   logic        o_busy;
   logic        o_done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem [352];
   logic [11:0] got [256];
   int          n_got, n_acc, n_done, stable_err;
   bit          timed_out;

   decompress_unpack dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_start       (i_start),
      .i_d           (i_d),
      .i_byte        (i_byte),
      .i_byte_valid  (i_byte_valid),
      .o_byte_ready  (o_byte_ready),
      .o_coeff       (o_coeff),
      .o_coeff_valid (o_coeff_valid),
      .i_coeff_ready (i_coeff_ready),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 i_clk = ~i_clk;

   // Reference: pull field j straight out of the byte array bit by bit.
   function automatic int exp_coeff(input int d, input int j);
      int y;
      int k;
      y = 0;
      for (int b = 0; b < d; b++) begin
         k = j * d + b;
         if (mem[k / 8][k % 8]) y += (1 << b);
      end
      return (3329 * y + (1 << (d - 1))) >> d;
   endfunction

   task automatic do_start(input logic [3:0] d);
      @(negedge i_clk);
      i_d     = d;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      i_d     = 4'd0;
   endtask

   // Feeds bytes (offering filler past the end) and collects coefficients
   // until target handshakes, then idles post cycles watching o_done.
   task automatic run_poly(input int d, input bit gaps, input bit stalls,
                           input int target, input int post);
      int          idx;
      bit          hold;
      logic [11:0] held;
      n_got = 0; n_acc = 0; n_done = 0; stable_err = 0; timed_out = 0;
      idx = 0; hold = 0; held = '0;
      for (int j = 0; j < 256; j++) got[j] = 'x;
      for (int cyc = 0; cyc < 20000 && n_got < target; cyc++) begin
         @(negedge i_clk);
         if (o_done) n_done++;
         if (hold && (!o_coeff_valid || o_coeff !== held)) stable_err++;
         i_byte        = (idx < 32 * d) ? mem[idx] : 8'hEE;
         i_byte_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         i_coeff_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         if (o_byte_ready && i_byte_valid) begin
            n_acc++;
            idx++;
         end
         if (o_coeff_valid && i_coeff_ready) begin
            got[n_got] = o_coeff;
            n_got++;
         end
         hold = o_coeff_valid && !i_coeff_ready;
         held = o_coeff;
      end
      if (n_got < target) timed_out = 1;
      for (int c = 0; c < post; c++) begin
         @(negedge i_clk);
         if (o_done) n_done++;
         i_byte        = 8'hEE;
         i_byte_valid  = 1'b1;
         i_coeff_ready = 1'b1;
         #1;
         if (o_byte_ready && i_byte_valid) n_acc++;
      end
      i_byte_valid = 1'b0;
   endtask

   task automatic test_reset;
      i_rstn = 1'b0; i_start = 1'b0; i_d = '0; i_byte = '0;
      i_byte_valid = 1'b0; i_coeff_ready = 1'b0;
      #12;
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_cmp++; if (o_byte_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", o_byte_ready); end
      n_cmp++; if (o_coeff_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_coeff_valid); end
      n_cmp++; if (o_coeff !== 12'd0) begin n_bad++; $display("FAIL reset_coeff: got %0d want 0", o_coeff); end
      n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
      @(negedge i_clk);
      i_rstn = 1'b1;
   endtask

   task automatic test_d1;
      int pat [8] = '{1665, 0, 1665, 0, 0, 1665, 0, 1665};
      for (int i = 0; i < 352; i++) mem[i] = 8'hA5;
      do_start(4'd1);
      n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL d1_busy_after_start: got %b want 1", o_busy); end
      run_poly(1, 0, 0, 256, 3);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL d1_timeout: got %0d coeffs want 256", n_got); end
      for (int j = 0; j < 256; j++) begin
         n_cmp++;
         if (got[j] !== 12'(pat[j % 8])) begin n_bad++; $display("FAIL d1_coeff[%0d]: got %0d want %0d", j, got[j], pat[j % 8]); end
      end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL d1_done_pulses: got %0d want 1", n_done); end
      n_cmp++; if (n_acc != 32) begin n_bad++; $display("FAIL d1_bytes: got %0d want 32", n_acc); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL d1_busy_end: got %b want 0", o_busy); end
   endtask

   task automatic test_d11;
      for (int i = 0; i < 352; i++) mem[i] = 8'hFF;
      do_start(4'd11);
      run_poly(11, 0, 0, 256, 3);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL d11_timeout: got %0d coeffs want 256", n_got); end
      for (int j = 0; j < 256; j++) begin
         n_cmp++;
         if (got[j] !== 12'd3327) begin n_bad++; $display("FAIL d11_ff_coeff[%0d]: got %0d want 3327", j, got[j]); end
      end
      n_cmp++; if (n_acc != 352) begin n_bad++; $display("FAIL d11_bytes: got %0d want 352", n_acc); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL d11_done_pulses: got %0d want 1", n_done); end
      for (int i = 0; i < 352; i++) mem[i] = 8'h00;
      mem[0] = 8'h01;
      do_start(4'd11);
      run_poly(11, 0, 0, 256, 3);
      n_cmp++; if (got[0] !== 12'd2) begin n_bad++; $display("FAIL d11_y1: got %0d want 2", got[0]); end
      n_cmp++; if (got[1] !== 12'd0) begin n_bad++; $display("FAIL d11_y0: got %0d want 0", got[1]); end
   endtask

   task automatic test_nibble_order;
      for (int i = 0; i < 352; i++) mem[i] = 8'h00;
      mem[0] = 8'hF0;
      do_start(4'd4);
      run_poly(4, 0, 0, 256, 3);
      n_cmp++; if (got[0] !== 12'd0) begin n_bad++; $display("FAIL d4_low_nibble: got %0d want 0", got[0]); end
      n_cmp++; if (got[1] !== 12'd3121) begin n_bad++; $display("FAIL d4_high_nibble: got %0d want 3121", got[1]); end
      n_cmp++; if (n_acc != 128) begin n_bad++; $display("FAIL d4_bytes: got %0d want 128", n_acc); end
      mem[0] = 8'h10;
      do_start(4'd5);
      run_poly(5, 0, 0, 256, 3);
      n_cmp++; if (got[0] !== 12'd1665) begin n_bad++; $display("FAIL d5_y16: got %0d want 1665", got[0]); end
      n_cmp++; if (got[1] !== 12'd0) begin n_bad++; $display("FAIL d5_second: got %0d want 0", got[1]); end
   endtask

   task automatic test_random_d10;
      for (int i = 0; i < 352; i++) mem[i] = 8'($urandom);
      do_start(4'd10);
      run_poly(10, 1, 1, 256, 4);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL d10_timeout: got %0d coeffs want 256", n_got); end
      for (int j = 0; j < 256; j++) begin
         n_cmp++;
         if (got[j] !== 12'(exp_coeff(10, j))) begin n_bad++; $display("FAIL d10_coeff[%0d]: got %0d want %0d", j, got[j], exp_coeff(10, j)); end
      end
      n_cmp++; if (stable_err != 0) begin n_bad++; $display("FAIL d10_hold_stable: got %0d violations want 0", stable_err); end
      n_cmp++; if (n_acc != 320) begin n_bad++; $display("FAIL d10_bytes: got %0d want 320", n_acc); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL d10_done_pulses: got %0d want 1", n_done); end
   endtask

   task automatic test_illegal_start;
      do_start(4'd3);
      for (int c = 0; c < 2; c++) begin
         n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL illegal_d_busy: got %b want 0", o_busy); end
         n_cmp++; if (o_byte_ready !== 1'b0) begin n_bad++; $display("FAIL illegal_d_ready: got %b want 0", o_byte_ready); end
         @(negedge i_clk);
      end
   endtask

   task automatic test_start_during_run;
      for (int i = 0; i < 352; i++) mem[i] = 8'(i * 37 + 5);
      do_start(4'd5);
      fork
         run_poly(5, 0, 0, 256, 3);
         begin
            repeat (20) @(negedge i_clk);
            i_d     = 4'd11;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
            i_d     = 4'd0;
         end
      join
      for (int j = 0; j < 256; j++) begin
         n_cmp++;
         if (got[j] !== 12'(exp_coeff(5, j))) begin n_bad++; $display("FAIL restart_coeff[%0d]: got %0d want %0d", j, got[j], exp_coeff(5, j)); end
      end
      n_cmp++; if (n_acc != 160) begin n_bad++; $display("FAIL restart_bytes: got %0d want 160", n_acc); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL restart_done_pulses: got %0d want 1", n_done); end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 352; i++) mem[i] = 8'($urandom);
      do_start(4'd10);
      run_poly(10, 1, 1, 100, 0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL midrst_timeout: got %0d coeffs want 100", n_got); end
      #2 i_rstn = 1'b0;
      #1;
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
      n_cmp++; if (o_byte_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", o_byte_ready); end
      n_cmp++; if (o_coeff_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", o_coeff_valid); end
      n_cmp++; if (o_coeff !== 12'd0) begin n_bad++; $display("FAIL midrst_coeff: got %0d want 0", o_coeff); end
      repeat (2) @(negedge i_clk);
      n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", o_done); end
      i_rstn = 1'b1;
      do_start(4'd10);
      run_poly(10, 0, 0, 256, 3);
      for (int j = 0; j < 256; j++) begin
         n_cmp++;
         if (got[j] !== 12'(exp_coeff(10, j))) begin n_bad++; $display("FAIL midrst_fresh_coeff[%0d]: got %0d want %0d", j, got[j], exp_coeff(10, j)); end
      end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL midrst_done_pulses: got %0d want 1", n_done); end
      n_cmp++; if (n_acc != 320) begin n_bad++; $display("FAIL midrst_bytes: got %0d want 320", n_acc); end
   endtask

   initial begin
      test_reset;
      test_d1;
      test_d11;
      test_nibble_order;
      test_random_d10;
      test_illegal_start;
      test_start_during_run;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
